grf_commit: RTL and testbench
=============================

Name: grf_commit

Overview:
- General register file: the receiving end of the writeback-stage interface (write address, write data, write enable, PC+8).
- Holds 32 x 32-bit MIPS GPRs and serves two combinational read ports to the decode stage.
- Maintains architectural commit state (commit counter, last-write record) for bench comparison against a golden model.
- Sits between the WB stage (write side) and the ID stage (read side) of the 5-stage pipeline.

Parameters:
- NREG, 32, number of registers. Fixed at 32; the address width is 5.
- DW, 32, data width.
- CNT_W, 32, width of commit_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable from WB (the RegWrite output of the WB stage).
- waddr  in  5  destination register from WB.
- wdata  in  32  write data from WB.
- wpc8  in  32  PC+8 of the instruction in WB.
- raddr1  in  5  read address, port 1 (rs).
- raddr2  in  5  read address, port 2 (rt).
- rdata1  out  32  read data, port 1.
- rdata2  out  32  read data, port 2.
- commit_cnt  out  CNT_W  number of architectural register writes performed.
- last_valid  out  1  at least one commit has occurred since reset.
- last_pc  out  32  PC of the most recent commit, equal to wpc8-8.
- last_addr  out  5  destination of the most recent commit.
- last_data  out  32  data of the most recent commit.

Behaviour:
- Reset:
  - reset_n=0 asynchronously clears all 32 registers, commit_cnt, last_valid, last_pc, last_addr and last_data to 0.
  - While reset_n=0, rdata1 and rdata2 read 0.
  - Deassertion is sampled on the clock; the first write can happen on the first rising edge with reset_n=1.
- Commit condition: a write is committed on a rising clock edge when we=1 and waddr!=0.
- Write (on a commit edge):
  - regs[waddr] <= wdata.
  - commit_cnt <= commit_cnt+1, wrapping modulo 2^CNT_W with no saturation.
  - last_pc <= wpc8-32'd8, computed mod 2^32 (wpc8=4 gives 0xFFFFFFFC).
  - last_addr <= waddr; last_data <= wdata; last_valid <= 1.
- Write to $0: we=1 with waddr=0 writes nothing, leaves commit_cnt unchanged and leaves the last_* outputs unchanged.
- Reads:
  - Combinational, zero latency.
  - raddr=0 always returns 0.
  - Otherwise the port returns regs[raddr], subject to the bypass rule under Optional Feature.
- Simultaneous events:
  - Both read ports may address the same register; each returns identical data.
  - Reads and a write to different addresses in the same cycle are independent.
- Reset mid-operation: reset_n falling in the same cycle as we=1 means the write is lost and every state element reads 0.
- X-handling: when we=0, waddr, wdata and wpc8 are don't-care and must not affect any state.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined (write-through): if we=1, waddr!=0 and raddrN==waddr, then rdataN=wdata in the same cycle, before the clock edge. This lets the pipeline drop its WB->ID forwarding path.
- Undefined: rdataN=regs[raddrN] only, so a same-cycle write becomes visible the cycle after the edge. The pipeline's hazard unit must then forward WB->ID itself.
- The $0 rule holds in both builds; there is no bypass for waddr=0.

Decomposition:
- The shared header holds:
  - GRF_ADDR_W=5, GRF_NREG=32, GRF_ZERO=5'd0, GRF_RA=5'd31.
  - PC8_OFFSET=32'd8.
  - The rs/rt/rd field macros already used by the pipeline.
- One sub-module, grf_read_port: a single read port containing the zero check and the optional bypass mux. It is instantiated twice.
- Storage and commit bookkeeping stay in grf_commit.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every read is 0; commit_cnt=0; last_valid=0.
- Write we=1, waddr=5, wdata=0xDEADBEEF, wpc8=0x00003008; next cycle read raddr1=5 -> rdata1=0xDEADBEEF, commit_cnt=1, last_pc=0x00003000, last_addr=5, last_valid=1.
- Write we=1, waddr=0, wdata=0x12345678 -> raddr=0 reads 0; commit_cnt and last_* are unchanged.
- Same-cycle write waddr=31, wdata=0x00003010 with raddr2=31:
  - GRF_BYPASS_EN defined -> rdata2=0x00003010 before the edge.
  - Undefined -> rdata2 shows the old value until after the edge.
- Assert reset_n=0 asynchronously mid-cycle after 10 writes -> registers and commit_cnt go to 0 immediately, without waiting for a clock edge; a we=1 in that cycle has no effect.
- Preload commit_cnt to 0xFFFFFFFF by forced-state or a reduced CNT_W=4 build with 15 commits, then one more commit -> commit_cnt wraps to 0; last_* are updated normally.

Source files
------------

// File: rtl/grf_commit_pkg.sv
// Shared GPR constants, instruction field helpers and the commit record type
// used by the grf_commit register file.
package grf_commit_pkg;

    localparam int unsigned GRF_ADDR_W = 5;
    localparam int unsigned GRF_NREG   = 32;
    localparam int unsigned GRF_DW     = 32;

    localparam logic [GRF_ADDR_W-1:0] GRF_ZERO   = 5'd0;
    localparam logic [GRF_ADDR_W-1:0] GRF_RA     = 5'd31;
    localparam logic [31:0]           PC8_OFFSET = 32'd8;

    typedef logic [GRF_ADDR_W-1:0] grf_addr_t;

    typedef struct packed {
        logic [31:0]       pc;
        grf_addr_t         addr;
        logic [GRF_DW-1:0] data;
    } commit_rec_t;

    function automatic grf_addr_t f_rs(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic grf_addr_t f_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic grf_addr_t f_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

endpackage

// File: rtl/grf_commit_if.sv
// Writeback-to-register-file and decode read-port bundle; the master side is
// the pipeline (WB writes, ID reads), the slave side is the register file.
interface grf_commit_if #(
    parameter int unsigned DW = grf_commit_pkg::GRF_DW
);
    import grf_commit_pkg::*;

    logic          we;
    grf_addr_t     waddr;
    logic [DW-1:0] wdata;
    logic [31:0]   wpc8;
    grf_addr_t     raddr1;
    grf_addr_t     raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;

    modport master (
        output we, waddr, wdata, wpc8, raddr1, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, wpc8, raddr1, raddr2,
        output rdata1, rdata2
    );

endinterface

// File: rtl/grf_read_port.sv
// One combinational GPR read port: $0 forces zero, and with GRF_BYPASS_EN
// defined a same-cycle write to the addressed register is passed straight through.
module grf_read_port
    import grf_commit_pkg::*;
#(
    parameter int unsigned DW = GRF_DW
) (
    input  logic          i_rst_n,
    input  grf_addr_t     i_raddr,
    input  logic [DW-1:0] i_rdata_reg,
    input  logic          i_we,
    input  grf_addr_t     i_waddr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

`ifdef GRF_BYPASS_EN
    logic w_hit;
    // Bypass is gated by reset so reads stay zero while reset_n is low.
    assign w_hit = i_rst_n && i_we && (i_waddr != GRF_ZERO) && (i_waddr == i_raddr);
`else
    logic w_hit;
    logic w_unused;
    assign w_hit    = 1'b0;
    assign w_unused = ^{i_rst_n, i_we, i_waddr, i_wdata};
`endif

    always_comb begin
        o_rdata = i_rdata_reg;
        if (i_raddr == GRF_ZERO) begin
            o_rdata = '0;
        end else if (w_hit) begin
            o_rdata = i_wdata;
        end
    end

endmodule

// File: rtl/grf_commit.sv
// MIPS general register file with architectural commit bookkeeping.
// Optional write-through read bypass is enabled by defining GRF_BYPASS_EN.
module grf_commit
    import grf_commit_pkg::*;
#(
    parameter int unsigned NREG  = GRF_NREG,
    parameter int unsigned DW    = GRF_DW,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    grf_commit_if.slave        wb,
    output logic [CNT_W-1:0]   commit_cnt,
    output logic               last_valid,
    output logic [31:0]        last_pc,
    output grf_addr_t          last_addr,
    output logic [DW-1:0]      last_data
);

    logic [DW-1:0]    r_regs [NREG];
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_valid;
    commit_rec_t      r_last;
    logic             w_commit;

    assign w_commit = wb.we && (wb.waddr != GRF_ZERO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_cnt        <= '0;
            r_last_valid <= 1'b0;
            r_last       <= '0;
        end else if (w_commit) begin
            r_regs[wb.waddr] <= wb.wdata;
            r_cnt            <= r_cnt + CNT_W'(1);
            r_last_valid     <= 1'b1;
            r_last.pc        <= wb.wpc8 - PC8_OFFSET;
            r_last.addr      <= wb.waddr;
            r_last.data      <= wb.wdata;
        end
    end

    assign commit_cnt = r_cnt;
    assign last_valid = r_last_valid;
    assign last_pc    = r_last.pc;
    assign last_addr  = r_last.addr;
    assign last_data  = r_last.data;

    grf_read_port #(.DW(DW)) u_rd1 (
        .i_rst_n     (reset_n),
        .i_raddr     (wb.raddr1),
        .i_rdata_reg (r_regs[wb.raddr1]),
        .i_we        (wb.we),
        .i_waddr     (wb.waddr),
        .i_wdata     (wb.wdata),
        .o_rdata     (wb.rdata1)
    );

    grf_read_port #(.DW(DW)) u_rd2 (
        .i_rst_n     (reset_n),
        .i_raddr     (wb.raddr2),
        .i_rdata_reg (r_regs[wb.raddr2]),
        .i_we        (wb.we),
        .i_waddr     (wb.waddr),
        .i_wdata     (wb.wdata),
        .o_rdata     (wb.rdata2)
    );

endmodule

// File: tb/tb_grf_commit.sv
// Scoreboard bench for grf_commit: a full-width instance and a CNT_W=4 instance
// receive identical stimulus; expected values come from a behavioural GPR model.
module tb_grf_commit;
    import grf_commit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        r_we;
    grf_addr_t   r_waddr, r_raddr1, r_raddr2;
    logic [31:0] r_wdata, r_wpc8;

    always #5 clk = ~clk;

    grf_commit_if #(.DW(32)) u_if ();
    grf_commit_if #(.DW(32)) u_if4 ();

    assign u_if.we      = r_we;
    assign u_if.waddr   = r_waddr;
    assign u_if.wdata   = r_wdata;
    assign u_if.wpc8    = r_wpc8;
    assign u_if.raddr1  = r_raddr1;
    assign u_if.raddr2  = r_raddr2;
    assign u_if4.we     = r_we;
    assign u_if4.waddr  = r_waddr;
    assign u_if4.wdata  = r_wdata;
    assign u_if4.wpc8   = r_wpc8;
    assign u_if4.raddr1 = r_raddr1;
    assign u_if4.raddr2 = r_raddr2;

    logic [31:0] cnt, lpc, ld, lpc4, ld4;
    logic [3:0]  cnt4;
    logic        lv, lv4;
    grf_addr_t   la, la4;

    grf_commit #(.NREG(32), .DW(32), .CNT_W(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .wb(u_if),
        .commit_cnt(cnt), .last_valid(lv), .last_pc(lpc), .last_addr(la), .last_data(ld)
    );

    grf_commit #(.NREG(32), .DW(32), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .wb(u_if4),
        .commit_cnt(cnt4), .last_valid(lv4), .last_pc(lpc4), .last_addr(la4), .last_data(ld4)
    );

    // Reference model
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;
    logic        m_lv;
    logic [31:0] m_lpc, m_ld;
    grf_addr_t   m_la;

    typedef enum {K_RD1, K_RD2, K_RD1_4, K_RD2_4, K_CNT, K_CNT4, K_VALID, K_PC, K_ADDR,
                  K_DATA, K_VALID4, K_PC4, K_ADDR4, K_DATA4} kind_e;
    typedef struct {
        kind_e       k;
        logic [31:0] e;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_RD1:    return u_if.rdata1;
            K_RD2:    return u_if.rdata2;
            K_RD1_4:  return u_if4.rdata1;
            K_RD2_4:  return u_if4.rdata2;
            K_CNT:    return cnt;
            K_CNT4:   return {28'd0, cnt4};
            K_VALID:  return {31'd0, lv};
            K_PC:     return lpc;
            K_ADDR:   return {27'd0, la};
            K_DATA:   return ld;
            K_VALID4: return {31'd0, lv4};
            K_PC4:    return lpc4;
            K_ADDR4:  return {27'd0, la4};
            K_DATA4:  return ld4;
            default:  return 'x;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input grf_addr_t a);
        if (!reset_n || a == 5'd0) return 32'd0;
`ifdef GRF_BYPASS_EN
        if (r_we && r_waddr != 5'd0 && a == r_waddr) return r_wdata;
`endif
        return m_regs[a];
    endfunction

    task automatic push(input kind_e k, input logic [31:0] e);
        exp_t it;
        it.k = k;
        it.e = e;
        sb.push_back(it);
    endtask

    task automatic push_reads();
        push(K_RD1, exp_rd(r_raddr1));
        push(K_RD2, exp_rd(r_raddr2));
        push(K_RD1_4, exp_rd(r_raddr1));
        push(K_RD2_4, exp_rd(r_raddr2));
    endtask

    task automatic push_state();
        push(K_CNT, m_cnt);
        push(K_CNT4, {28'd0, m_cnt4});
        push(K_VALID, {31'd0, m_lv});
        push(K_PC, m_lpc);
        push(K_ADDR, {27'd0, m_la});
        push(K_DATA, m_ld);
        push(K_VALID4, {31'd0, m_lv});
        push(K_PC4, m_lpc);
        push(K_ADDR4, {27'd0, m_la});
        push(K_DATA4, m_ld);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            chk(it.k.name(), observe(it.k), it.e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt  = 32'd0;
        m_cnt4 = 4'd0;
        m_lv   = 1'b0;
        m_lpc  = 32'd0;
        m_la   = 5'd0;
        m_ld   = 32'd0;
    endtask

    task automatic model_edge();
        if (reset_n && r_we && r_waddr != 5'd0) begin
            m_regs[r_waddr] = r_wdata;
            m_cnt  = m_cnt + 32'd1;
            m_cnt4 = m_cnt4 + 4'd1;
            m_lv   = 1'b1;
            m_lpc  = r_wpc8 - 32'd8;
            m_la   = r_waddr;
            m_ld   = r_wdata;
        end
    endtask

    // Called at a falling edge: drive, check reads before the edge, check state after it.
    task automatic step(input logic we, input grf_addr_t wa, input logic [31:0] wd,
                        input logic [31:0] wp, input grf_addr_t a1, input grf_addr_t a2);
        r_we = we; r_waddr = wa; r_wdata = wd; r_wpc8 = wp;
        r_raddr1 = a1; r_raddr2 = a2;
        #1;
        push_reads();
        drain();
        @(posedge clk);
        model_edge();
        #1;
        push_state();
        drain();
        @(negedge clk);
    endtask

    task automatic idle(input grf_addr_t a1, input grf_addr_t a2);
        step(1'b0, 5'($urandom), $urandom, $urandom, a1, a2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        r_we = 1'b0; r_waddr = '0; r_wdata = '0; r_wpc8 = '0;
        r_raddr1 = '0; r_raddr2 = '0;
        model_reset();
        @(negedge clk);
        // Writes attempted while held in reset must be ignored and reads stay zero.
        r_we = 1'b1; r_waddr = 5'd7; r_wdata = 32'hFFFF_FFFF; r_wpc8 = 32'h100;
        r_raddr1 = 5'd7; r_raddr2 = 5'd7;
        #1; push_reads(); drain();
        @(posedge clk); #1; push_reads(); push_state(); drain();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        step(1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_3008, 5'd5, 5'd5);
        idle(5'd5, 5'd0);

        step(1'b1, 5'd0, 32'h1234_5678, 32'h0000_300C, 5'd0, 5'd5);
        idle(5'd0, 5'd5);

        step(1'b1, 5'd31, 32'h0000_3010, 32'h0000_4000, 5'd0, 5'd31);
        idle(5'd31, 5'd31);
        step(1'b1, 5'd31, 32'hCAFE_0001, 32'h0000_4004, 5'd31, 5'd5);
        idle(5'd31, 5'd5);

        step(1'b1, 5'd3, 32'h0000_1111, 32'd4, 5'd3, 5'd31);
        idle(5'd3, 5'd3);

        for (int i = 0; i < 10; i++) begin
            grf_addr_t a;
            a = 5'($urandom_range(1, 31));
            step(1'b1, a, $urandom, $urandom, a, 5'($urandom));
        end
        for (int i = 0; i < 8; i++) idle(5'($urandom), 5'($urandom));

        // Asynchronous reset mid-cycle with a pending write.
        r_we = 1'b1; r_waddr = 5'd9; r_wdata = 32'hAAAA_5555; r_wpc8 = 32'h200;
        r_raddr1 = 5'd9; r_raddr2 = 5'd5;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1; push_reads(); push_state(); drain();
        for (int i = 0; i < 32; i++) begin
            r_raddr1 = 5'(i); r_raddr2 = 5'(31 - i);
            #1; push_reads(); drain();
        end
        @(posedge clk); #1; push_state(); drain();
        @(negedge clk);
        reset_n = 1'b1;
        r_we = 1'b0;

        // Sixteen commits wrap the 4-bit counter instance back to zero.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 5'(i + 1), 32'h5000_0000 + 32'(i), 32'h8 + 32'(4 * i), 5'(i + 1), 5'(i));
        end
        chk("CNT4_WRAP", {28'd0, cnt4}, 32'd0);
        chk("CNT_16", cnt, 32'd16);
        idle(5'd16, 5'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
